// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter: FSM states,
// transaction owner encoding and the fetch-priority decision.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  localparam logic [3:0] BE_FULL      = 4'hF;
  localparam int         STARVE_CNT_W = 4;

  // Data wins unless fetch is waiting and has already been passed over
  // the maximum number of times.
  function automatic owner_t pick_owner(input logic if_req,
                                        input logic dm_req,
                                        input logic fetch_due);
    if (dm_req && !(if_req && fetch_due)) begin
      return OWN_DM;
    end
    return OWN_IF;
  endfunction

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of data grants made while fetch was waiting.
// Clear has priority over increment.
module mem_arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT_V = STARVE_CNT_W'(LIMIT);
  localparam logic [STARVE_CNT_W-1:0] ONE_V   = STARVE_CNT_W'(1);

  logic [STARVE_CNT_W-1:0] count_reg;
  logic [STARVE_CNT_W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (inc && (count_reg != LIMIT_V)) begin
      count_next = count_reg + ONE_V;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign at_limit = (count_reg == LIMIT_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single memory port between instruction fetch and the LSU.
// One transaction at a time: IDLE -> ISSUE -> WAIT -> RESP, all outputs registered.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH         = 32,
  parameter int ADDR_WIDTH         = 32,
  parameter int FETCH_STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_ack,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  input  logic [3:0]            dm_be,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  dm_ack,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_be,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  state_t state_reg, state_next;
  owner_t owner_reg, owner_next;
  owner_t grant_owner;

  logic                  mem_req_reg,   mem_req_next;
  logic                  mem_we_reg,    mem_we_next;
  logic [ADDR_WIDTH-1:0] mem_addr_reg,  mem_addr_next;
  logic [DATA_WIDTH-1:0] mem_wdata_reg, mem_wdata_next;
  logic [3:0]            mem_be_reg,    mem_be_next;
  logic                  if_ack_reg,    if_ack_next;
  logic                  dm_ack_reg,    dm_ack_next;
  logic [DATA_WIDTH-1:0] if_rdata_reg,  if_rdata_next;
  logic [DATA_WIDTH-1:0] dm_rdata_reg,  dm_rdata_next;
  logic                  busy_reg,      busy_next;

  logic any_req;
  logic starve_inc;
  logic starve_clr;
  logic fetch_due;

  assign any_req     = if_req | dm_req;
  assign grant_owner = pick_owner(if_req, dm_req, fetch_due);

  mem_arb_starve_ctr #(
    .LIMIT (FETCH_STARVE_LIMIT)
  ) u_starve_ctr (
    .clk      (clk),
    .rst      (rst),
    .inc      (starve_inc),
    .clr      (starve_clr),
    .at_limit (fetch_due)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (any_req)    state_next = ISSUE;
      ISSUE:   if (mem_gnt)    state_next = WAIT;
      WAIT:    if (mem_rvalid) state_next = RESP;
      RESP:                    state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // Next values of every registered output; anything not touched holds.
  always_comb begin
    owner_next     = owner_reg;
    mem_req_next   = mem_req_reg;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    mem_be_next    = mem_be_reg;
    if_ack_next    = 1'b0;
    dm_ack_next    = 1'b0;
    if_rdata_next  = if_rdata_reg;
    dm_rdata_next  = dm_rdata_reg;
    starve_inc     = 1'b0;
    starve_clr     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (any_req) begin
          owner_next   = grant_owner;
          mem_req_next = 1'b1;
          if (grant_owner == OWN_DM) begin
            mem_we_next    = dm_we;
            mem_addr_next  = dm_addr;
            mem_wdata_next = dm_wdata;
            mem_be_next    = dm_be;
            starve_inc     = if_req;
            starve_clr     = !if_req;
          end else begin
            mem_we_next    = 1'b0;
            mem_addr_next  = if_addr;
            mem_wdata_next = '0;
            mem_be_next    = BE_FULL;
            starve_clr     = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (mem_gnt) begin
          mem_req_next = 1'b0;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          if (owner_reg == OWN_IF) begin
            if_ack_next   = 1'b1;
            if_rdata_next = mem_rdata;
          end else begin
            dm_ack_next = 1'b1;
            if (!mem_we_reg) begin
              dm_rdata_next = mem_rdata;
            end
          end
        end
      end
      default: ;
    endcase

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      owner_reg     <= OWN_IF;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_be_reg    <= '0;
      if_ack_reg    <= 1'b0;
      dm_ack_reg    <= 1'b0;
      if_rdata_reg  <= '0;
      dm_rdata_reg  <= '0;
      busy_reg      <= 1'b0;
    end else begin
      owner_reg     <= owner_next;
      mem_req_reg   <= mem_req_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      mem_be_reg    <= mem_be_next;
      if_ack_reg    <= if_ack_next;
      dm_ack_reg    <= dm_ack_next;
      if_rdata_reg  <= if_rdata_next;
      dm_rdata_reg  <= dm_rdata_next;
      busy_reg      <= busy_next;
    end
  end

  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign mem_be    = mem_be_reg;
  assign if_ack    = if_ack_reg;
  assign dm_ack    = dm_ack_reg;
  assign if_rdata  = if_rdata_reg;
  assign dm_rdata  = dm_rdata_reg;
  assign busy      = busy_reg;

endmodule
